// File: rtl/branch_commit_unit.sv
// Purpose : tracks in-flight branches/JALs by ROB index from dispatch to commit;
//           emits predictor training updates and mispredict redirects at commit.
// Latency : commit -> br_upd_valid / mispredict / redirect_pc is 1 cycle; head_resolved is combinational.
// Backpr. : rdy=0 freezes all state and outputs and ignores every input, so a pending pulse
//           is held and seen exactly once on the next rdy cycle.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   rdy                    global ready (0 = freeze)
//   flush                  external flush, invalidates every entry
//   alloc_*                dispatch writes a new branch entry at alloc_idx
//   res_*                  ALU outcome (direction, taken target) for res_idx
//   commit_valid/idx       ROB head commits the branch at commit_idx
//   head_resolved          entry[commit_idx] valid and resolved (same-cycle resolve forwarded)
//   br_upd_valid/jump/pc   one-cycle predictor training pulse
//   mispredict/redirect_pc one-cycle flush pulse with corrected fetch PC
//   proto_err              sticky: commit of an invalid or unresolved entry
module branch_commit_unit #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [IDX_W-1:0] alloc_idx,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_pred_jump,
    input  logic [31:0]      alloc_pred_pc,
    input  logic             res_valid,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             res_jump,
    input  logic [31:0]      res_target,
    input  logic             commit_valid,
    input  logic [IDX_W-1:0] commit_idx,
    output logic             head_resolved,
    output logic             br_upd_valid,
    output logic             br_upd_jump,
    output logic [31:0]      br_upd_pc,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             proto_err
);

    localparam int DEPTH = 1 << IDX_W;

    typedef struct packed {
        logic        valid;
        logic        resolved;
        logic [31:0] pc;
        logic        pred_jump;
        logic [31:0] pred_pc;
        logic        act_jump;
        logic [31:0] act_target;
    } entry_t;

    entry_t      ent_q [DEPTH];
    entry_t      ent_d [DEPTH];

    logic        br_upd_valid_q, br_upd_valid_d;
    logic        br_upd_jump_q,  br_upd_jump_d;
    logic [31:0] br_upd_pc_q,    br_upd_pc_d;
    logic        mispredict_q,   mispredict_d;
    logic [31:0] redirect_pc_q,  redirect_pc_d;
    logic        proto_err_q,    proto_err_d;

    // Commit-side view of the head entry, with a same-cycle resolve forwarded in.
    entry_t      head;
    logic        alloc_ok;
    logic        res_ok;
    logic        res_fwd;
    logic        commit_legal;
    logic        commit_bad;
    logic        cm_jump;
    logic [31:0] cm_target;
    logic        cm_mis;
    logic [31:0] cm_redirect;

    always_comb begin
        // While a redirect is being signalled the front end is being flushed,
        // so anything dispatched or resolved in that cycle is wrong-path.
        alloc_ok      = alloc_valid & ~mispredict_q;
        res_ok        = res_valid & ~mispredict_q;
        head          = ent_q[commit_idx];
        res_fwd       = res_ok & (res_idx == commit_idx);
        head_resolved = head.valid & (head.resolved | res_fwd);
        commit_legal  = commit_valid & head_resolved;
        commit_bad    = commit_valid & ~head_resolved;
        cm_jump       = res_fwd ? res_jump   : head.act_jump;
        cm_target     = res_fwd ? res_target : head.act_target;
        cm_mis        = (cm_jump != head.pred_jump) |
                        (cm_jump & (cm_target != head.pred_pc));
        cm_redirect   = cm_jump ? cm_target : (head.pc + 32'd4);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        br_upd_valid_d = br_upd_valid_q;
        br_upd_jump_d  = br_upd_jump_q;
        br_upd_pc_d    = br_upd_pc_q;
        mispredict_d   = mispredict_q;
        redirect_pc_d  = redirect_pc_q;
        proto_err_d    = proto_err_q;

        if (rdy) begin
            br_upd_valid_d = commit_legal;
            mispredict_d   = commit_legal & cm_mis;
            if (commit_legal) begin
                br_upd_jump_d = cm_jump;
                br_upd_pc_d   = head.pc;
                redirect_pc_d = cm_redirect;
            end
            if (commit_bad) begin
                proto_err_d = 1'b1;
            end

            // A resolve colliding with an allocation belongs to the entry
            // being overwritten, so it is discarded.
            if (res_ok && ent_q[res_idx].valid &&
                !(alloc_ok && (alloc_idx == res_idx))) begin
                ent_d[res_idx].resolved   = 1'b1;
                ent_d[res_idx].act_jump   = res_jump;
                ent_d[res_idx].act_target = res_target;
            end

            // Retire before allocate: on ROB wrap the new entry must survive.
            if (commit_legal) begin
                ent_d[commit_idx].valid = 1'b0;
            end

            if (alloc_ok) begin
                ent_d[alloc_idx].valid      = 1'b1;
                ent_d[alloc_idx].resolved   = 1'b0;
                ent_d[alloc_idx].pc         = alloc_pc;
                ent_d[alloc_idx].pred_jump  = alloc_pred_jump;
                ent_d[alloc_idx].pred_pc    = alloc_pred_pc;
                ent_d[alloc_idx].act_jump   = 1'b0;
                ent_d[alloc_idx].act_target = 32'd0;
            end

            // Everything younger than a mispredicted branch, or anything at
            // all on an external flush, is squashed.
            if (flush || (commit_legal && cm_mis)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i].valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            br_upd_valid_q <= 1'b0;
            br_upd_jump_q  <= 1'b0;
            br_upd_pc_q    <= 32'd0;
            mispredict_q   <= 1'b0;
            redirect_pc_q  <= 32'd0;
            proto_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            br_upd_valid_q <= br_upd_valid_d;
            br_upd_jump_q  <= br_upd_jump_d;
            br_upd_pc_q    <= br_upd_pc_d;
            mispredict_q   <= mispredict_d;
            redirect_pc_q  <= redirect_pc_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign br_upd_valid = br_upd_valid_q;
    assign br_upd_jump  = br_upd_jump_q;
    assign br_upd_pc    = br_upd_pc_q;
    assign mispredict   = mispredict_q;
    assign redirect_pc  = redirect_pc_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_branch_commit_unit.sv
// Purpose : directed table-driven bench for branch_commit_unit plus hand sequences
//           for protocol error, stall hold and reset.
// Latency : each vector is one clock; head_resolved checked before the edge, pulses after it.
// Backpr. : rdy is held high in the table and dropped only in the stall sequence.
module tb_branch_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        alloc_valid;
    logic [3:0]  alloc_idx;
    logic [31:0] alloc_pc;
    logic        alloc_pred_jump;
    logic [31:0] alloc_pred_pc;
    logic        res_valid;
    logic [3:0]  res_idx;
    logic        res_jump;
    logic [31:0] res_target;
    logic        commit_valid;
    logic [3:0]  commit_idx;
    logic        head_resolved;
    logic        br_upd_valid;
    logic        br_upd_jump;
    logic [31:0] br_upd_pc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        proto_err;

    always #5 clk = ~clk;

    branch_commit_unit #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_pc(alloc_pc),
        .alloc_pred_jump(alloc_pred_jump), .alloc_pred_pc(alloc_pred_pc),
        .res_valid(res_valid), .res_idx(res_idx), .res_jump(res_jump),
        .res_target(res_target),
        .commit_valid(commit_valid), .commit_idx(commit_idx),
        .head_resolved(head_resolved),
        .br_upd_valid(br_upd_valid), .br_upd_jump(br_upd_jump), .br_upd_pc(br_upd_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .proto_err(proto_err)
    );

    typedef struct {
        logic        fl;
        logic        av;
        logic [3:0]  ai;
        logic [31:0] apc;
        logic        apj;
        logic [31:0] appc;
        logic        rv;
        logic [3:0]  ri;
        logic        rj;
        logic [31:0] rt;
        logic        cv;
        logic [3:0]  ci;
        logic        e_hr;
        logic        e_upd;
        logic        e_jump;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   pulse_cnt = 0;
    logic cnt_en = 1'b0;

    always @(posedge clk) begin
        if (cnt_en && rdy && br_upd_valid) pulse_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(
        input logic fl, input logic av, input logic [3:0] ai, input logic [31:0] apc,
        input logic apj, input logic [31:0] appc,
        input logic rv, input logic [3:0] ri, input logic rj, input logic [31:0] rt,
        input logic cv, input logic [3:0] ci,
        input logic e_hr, input logic e_upd, input logic e_jump, input logic [31:0] e_pc,
        input logic e_mis, input logic [31:0] e_redir);
        vec_t v;
        v.fl = fl; v.av = av; v.ai = ai; v.apc = apc; v.apj = apj; v.appc = appc;
        v.rv = rv; v.ri = ri; v.rj = rj; v.rt = rt; v.cv = cv; v.ci = ci;
        v.e_hr = e_hr; v.e_upd = e_upd; v.e_jump = e_jump; v.e_pc = e_pc;
        v.e_mis = e_mis; v.e_redir = e_redir;
        return v;
    endfunction

    task automatic idle_inputs();
        flush = 1'b0; alloc_valid = 1'b0; alloc_idx = '0; alloc_pc = '0;
        alloc_pred_jump = 1'b0; alloc_pred_pc = '0;
        res_valid = 1'b0; res_idx = '0; res_jump = 1'b0; res_target = '0;
        commit_valid = 1'b0; commit_idx = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_upd_valid"}, {31'd0, br_upd_valid}, 32'd0);
        check({tag, "_upd_jump"},  {31'd0, br_upd_jump},  32'd0);
        check({tag, "_upd_pc"},    br_upd_pc,             32'd0);
        check({tag, "_mispredict"}, {31'd0, mispredict},  32'd0);
        check({tag, "_redirect"},  redirect_pc,           32'd0);
        check({tag, "_proto_err"}, {31'd0, proto_err},    32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle_inputs();

        //        fl av ai  apc           apj appc          rv ri rj rt          cv ci  hr upd jmp pc            mis redir
        vecs.push_back(mk(0,1,3, 32'h100,     0, 32'h104,     0,0, 0,32'h0,     0,3,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       1,3, 0,32'h0,     0,3,  1,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     1,3,  1,1,0,32'h100,       0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     0,3,  0,0,0,32'h0,         0,32'h0));
        // predicted taken, actually not taken
        vecs.push_back(mk(0,1,4, 32'h300,     1, 32'h380,     0,0, 0,32'h0,     0,4,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       1,4, 0,32'h380,   0,4,  1,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     1,4,  1,1,0,32'h300,       1,32'h304));
        vecs.push_back(mk(0,1,6, 32'h500,     0, 32'h504,     0,0, 0,32'h0,     0,6,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     0,6,  0,0,0,32'h0,         0,32'h0));
        // resolve and commit in the same cycle, correctly predicted taken
        vecs.push_back(mk(0,1,7, 32'h70,      1, 32'h80,      0,0, 0,32'h0,     0,7,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       1,7, 1,32'h80,    1,7,  1,1,1,32'h70,        0,32'h0));
        // wrong taken target; mispredict squashes entry 9 and ignores next alloc/res
        vecs.push_back(mk(0,1,5, 32'h200,     1, 32'h240,     0,0, 0,32'h0,     0,5,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,1,9, 32'h900,     0, 32'h904,     0,0, 0,32'h0,     0,9,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       1,5, 1,32'h260,   0,9,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     1,5,  1,1,1,32'h200,       1,32'h260));
        vecs.push_back(mk(0,1,1, 32'h10,      0, 32'h14,      1,9, 0,32'h0,     0,9,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     0,1,  0,0,0,32'h0,         0,32'h0));
        // alloc and commit on the same index (ROB wrap)
        vecs.push_back(mk(0,1,10,32'hA00,     0, 32'hA04,     0,0, 0,32'h0,     0,10, 0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       1,10,0,32'h0,     0,10, 1,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,1,10,32'hB00,     0, 32'hB04,     0,0, 0,32'h0,     1,10, 1,1,0,32'hA00,       0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     0,10, 0,0,0,32'h0,         0,32'h0));
        // alloc and resolve on the same index: resolve dropped
        vecs.push_back(mk(0,1,11,32'hB10,     0, 32'hB14,     0,0, 0,32'h0,     0,11, 0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,1,11,32'hB20,     0, 32'hB24,     1,11,1,32'h999,   0,0,  0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     0,11, 0,0,0,32'h0,         0,32'h0));
        // commit concurrent with flush still emits; resolved entry 12 is flushed
        vecs.push_back(mk(0,1,12,32'hC00,     0, 32'hC04,     1,10,0,32'h0,     0,10, 1,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(1,0,0, 32'h0,       0, 32'h0,       1,12,0,32'h0,     1,10, 1,1,0,32'hB00,       0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     0,12, 0,0,0,32'h0,         0,32'h0));
        // resolve of an invalid entry is dropped
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       1,13,0,32'h0,     0,13, 0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,1,13,32'hD00,     0, 32'hD04,     0,0, 0,32'h0,     0,13, 0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     0,13, 0,0,0,32'h0,         0,32'h0));
        // pc+4 wraps modulo 2**32
        vecs.push_back(mk(0,1,14,32'hFFFFFFFC,1, 32'h0,       0,0, 0,32'h0,     0,14, 0,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       1,14,0,32'h0,     0,14, 1,0,0,32'h0,         0,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     1,14, 1,1,0,32'hFFFFFFFC,  1,32'h0));
        vecs.push_back(mk(0,0,0, 32'h0,       0, 32'h0,       0,0, 0,32'h0,     0,0,  0,0,0,32'h0,         0,32'h0));

        do_reset();
        #1;
        check_reset_state("reset");
        check("reset_head_resolved", {31'd0, head_resolved}, 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            flush = vecs[i].fl;
            alloc_valid = vecs[i].av; alloc_idx = vecs[i].ai; alloc_pc = vecs[i].apc;
            alloc_pred_jump = vecs[i].apj; alloc_pred_pc = vecs[i].appc;
            res_valid = vecs[i].rv; res_idx = vecs[i].ri; res_jump = vecs[i].rj;
            res_target = vecs[i].rt;
            commit_valid = vecs[i].cv; commit_idx = vecs[i].ci;
            #1;
            check($sformatf("v%0d_head_resolved", i), {31'd0, head_resolved}, {31'd0, vecs[i].e_hr});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_upd_valid", i), {31'd0, br_upd_valid}, {31'd0, vecs[i].e_upd});
            check($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
            check($sformatf("v%0d_proto_err", i), {31'd0, proto_err}, 32'd0);
            if (vecs[i].e_upd) begin
                check($sformatf("v%0d_upd_jump", i), {31'd0, br_upd_jump}, {31'd0, vecs[i].e_jump});
                check($sformatf("v%0d_upd_pc", i), br_upd_pc, vecs[i].e_pc);
            end
            if (vecs[i].e_mis) begin
                check($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].e_redir);
            end
        end

        // Commit of a never-allocated entry: no pulses, sticky proto_err.
        @(negedge clk);
        idle_inputs();
        commit_valid = 1'b1; commit_idx = 4'd2;
        #1;
        check("perr_head_resolved", {31'd0, head_resolved}, 32'd0);
        @(posedge clk);
        #1;
        check("perr_upd_valid", {31'd0, br_upd_valid}, 32'd0);
        check("perr_mispredict", {31'd0, mispredict}, 32'd0);
        check("perr_set", {31'd0, proto_err}, 32'd1);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("perr_sticky%0d", k), {31'd0, proto_err}, 32'd1);
        end
        do_reset();
        #1;
        check_reset_state("rereset");

        // Legal commit followed by a 3-cycle stall: pulse holds, seen once.
        cnt_en = 1'b1;
        @(negedge clk);
        idle_inputs();
        alloc_valid = 1'b1; alloc_idx = 4'd3; alloc_pc = 32'h100;
        alloc_pred_jump = 1'b0; alloc_pred_pc = 32'h104;
        @(negedge clk);
        idle_inputs();
        res_valid = 1'b1; res_idx = 4'd3; res_jump = 1'b0;
        @(negedge clk);
        idle_inputs();
        commit_valid = 1'b1; commit_idx = 4'd3;
        @(posedge clk);
        #1;
        check("stall_pulse_start", {31'd0, br_upd_valid}, 32'd1);
        check("stall_pulse_pc", br_upd_pc, 32'h100);
        @(negedge clk);
        idle_inputs();
        rdy = 1'b0;
        alloc_valid = 1'b1; alloc_idx = 4'd8; alloc_pc = 32'h800;
        commit_valid = 1'b1; commit_idx = 4'd9;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_hold%0d", k), {31'd0, br_upd_valid}, 32'd1);
            check($sformatf("stall_perr%0d", k), {31'd0, proto_err}, 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        rdy = 1'b1;
        @(posedge clk);
        #1;
        check("stall_pulse_drop", {31'd0, br_upd_valid}, 32'd0);
        @(negedge clk);
        commit_idx = 4'd8;
        #1;
        check("stall_alloc_ignored", {31'd0, head_resolved}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("stall_pulse_count", pulse_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
